vector_alu_unit: RTL

- Multi-lane, multi-beat vector ALU for the vector execution stage; processes a full vector register group per instruction.
- Each beat runs LANE_NUM element ALUs in parallel; the element groups are sequenced by an FSM.
- Applies the element mask, vl tail handling, and VV/VX/VI operand selection.
- Valid/ready handshake on input and output; the result vector is held until consumed.

---
 rtl/vector_alu_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vector_alu_unit.sv
// vector_alu_unit: multi-beat vector ALU, LANE_NUM element ALUs per beat with mask/tail/VV-VX-VI select.
// Define VECTOR_ALU_REDUCE_EN to add the red_sum vs2 sum reduction into element 0.
module vector_alu_unit #(
  parameter int LEN = 32,
  parameter int VECTOR_SIZE = 8,
  parameter int LANE_NUM = 2,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    alu_signal,
  input  logic [1:0]                    vec_operand_type,
  input  logic                          red_sum,
  input  logic                          vm,
  input  logic [ENTRY_INDEX_SIZE:0]     vl,
  input  logic [VECTOR_SIZE*LEN-1:0]    vs1,
  input  logic [VECTOR_SIZE*LEN-1:0]    vs2,
  input  logic [VECTOR_SIZE*LEN-1:0]    vd_old,
  input  logic [VECTOR_SIZE-1:0]        mask,
  input  logic [LEN-1:0]                imm,
  input  logic [LEN-1:0]                rs,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VECTOR_SIZE*LEN-1:0]    result,
  output logic                          busy
);
  localparam int VW = ENTRY_INDEX_SIZE + 1;
  localparam int SW = $clog2(LEN);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_q;
  logic [1:0] opt_q;
  logic vm_q;
  logic [VW-1:0] vl_q, nb_q, beat, in_vl_c, in_nb;
  logic [VECTOR_SIZE*LEN-1:0] vs1_q, vs2_q;
  logic [VECTOR_SIZE-1:0] mask_q;
  logic [LEN-1:0] imm_q, rs_q;
  logic [ENTRY_INDEX_SIZE-1:0] lane_idx [LANE_NUM];
  logic [LEN-1:0] lane_a [LANE_NUM];
  logic [LEN-1:0] lane_val [LANE_NUM];
  logic [LANE_NUM-1:0] lane_act;
  assign in_vl_c = (vl > VW'(VECTOR_SIZE)) ? VW'(VECTOR_SIZE) : vl;
  assign in_nb = VW'((int'(in_vl_c) + LANE_NUM - 1) / LANE_NUM);
  assign in_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign out_valid = (state == DONE);
  for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane
    logic [LEN-1:0] b;
    logic signed [LEN-1:0] sra;
    assign lane_idx[g] = ENTRY_INDEX_SIZE'(int'(beat) * LANE_NUM + g);
    assign lane_a[g] = vs2_q[lane_idx[g]*LEN +: LEN];
    assign b = (opt_q == 2'b01) ? rs_q : (opt_q == 2'b10) ? imm_q : vs1_q[lane_idx[g]*LEN +: LEN];
    assign sra = $signed(lane_a[g]) >>> b[SW-1:0];
    assign lane_act[g] = ({1'b0, lane_idx[g]} < vl_q) && (vm_q || mask_q[lane_idx[g]]);
    assign lane_val[g] = (op_q == 3'd0) ? lane_a[g] + b :
                         (op_q == 3'd1) ? lane_a[g] - b :
                         (op_q == 3'd2) ? lane_a[g] & b :
                         (op_q == 3'd3) ? lane_a[g] | b :
                         (op_q == 3'd4) ? lane_a[g] ^ b :
                         (op_q == 3'd5) ? lane_a[g] << b[SW-1:0] :
                         (op_q == 3'd6) ? lane_a[g] >> b[SW-1:0] : sra;
  end
`ifdef VECTOR_ALU_REDUCE_EN
  logic red_q;
  logic [LEN-1:0] red_add;
  always_comb begin
    red_add = '0;
    for (int l = 0; l < LANE_NUM; l++) red_add = red_add + (lane_act[l] ? lane_a[l] : '0);
  end
`else
  logic unused_red;
  assign unused_red = red_sum;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? ((in_nb == '0) ? DONE : EXEC) : IDLE;
      EXEC: state_nx = (beat == nb_q - VW'(1)) ? DONE : EXEC;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // result doubles as the reduction accumulator (element 0) so DONE needs no final merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
      result <= '0;
      op_q <= '0;
      opt_q <= '0;
      vm_q <= 1'b0;
      vl_q <= '0;
      nb_q <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
      mask_q <= '0;
      imm_q <= '0;
      rs_q <= '0;
`ifdef VECTOR_ALU_REDUCE_EN
      red_q <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      beat <= '0;
      result <= vd_old;
      op_q <= alu_signal;
      opt_q <= vec_operand_type;
      vm_q <= vm;
      vl_q <= in_vl_c;
      nb_q <= in_nb;
      vs1_q <= vs1;
      vs2_q <= vs2;
      mask_q <= mask;
      imm_q <= imm;
      rs_q <= rs;
`ifdef VECTOR_ALU_REDUCE_EN
      red_q <= red_sum;
      if (red_sum) result[LEN-1:0] <= vs1[LEN-1:0];
`endif
    end else if (state == EXEC) begin
      beat <= beat + VW'(1);
`ifdef VECTOR_ALU_REDUCE_EN
      if (red_q) result[LEN-1:0] <= result[LEN-1:0] + red_add;
      else
`endif
      for (int l = 0; l < LANE_NUM; l++)
        if (lane_act[l]) result[int'(lane_idx[l])*LEN +: LEN] <= lane_val[l];
    end
  end
endmodule
